// File: rtl/mp64_memctl_pkg.sv
// Shared definitions for the mp64 memory controller: size codes, FSM states
// and the byte-lane helpers used by both the controller and its BRAM.
package mp64_memctl_pkg;

    localparam logic [1:0] MEM_SZ_BYTE  = 2'd0;
    localparam logic [1:0] MEM_SZ_HALF  = 2'd1;
    localparam logic [1:0] MEM_SZ_WORD  = 2'd2;
    localparam logic [1:0] MEM_SZ_DWORD = 2'd3;

    localparam logic [63:0] ERR_RDATA_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        MC_IDLE     = 3'd0,
        MC_RD       = 3'd1,
        MC_EXT_WAIT = 3'd2,
        MC_ACK      = 3'd3,
        MC_DONE     = 3'd4
    } mc_state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    // Misaligned low address bits are dropped, aligning the access down.
    function automatic logic [2:0] byte_off(input logic [2:0] addr_lo, input logic [1:0] size);
        logic [3:0] lsb_mask;
        lsb_mask = size_bytes(size) - 4'd1;
        return addr_lo & ~lsb_mask[2:0];
    endfunction

    function automatic logic [7:0] byte_en(input logic [2:0] off, input logic [1:0] size);
        logic [15:0] lanes;
        lanes = (16'd1 << size_bytes(size)) - 16'd1;
        lanes = lanes << off;
        return lanes[7:0];
    endfunction

    function automatic logic [63:0] fmt_rdata(input logic [63:0] word, input logic [2:0] off,
                                              input logic [1:0] size);
        logic [63:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            MEM_SZ_BYTE: return {56'd0, shifted[7:0]};
            MEM_SZ_HALF: return {48'd0, shifted[15:0]};
            MEM_SZ_WORD: return {32'd0, shifted[31:0]};
            default:     return shifted;
        endcase
    endfunction

endpackage

// File: rtl/mp64_memctl_bram.sv
// 64-bit wide byte-enabled BRAM with a registered (1-cycle) read port.
// No reset on contents or read data so it maps onto block RAM.
module mp64_bram_be #(
    parameter int unsigned DEPTH = 8192,
    parameter int unsigned AW    = 13
) (
    input  logic          clk,
    input  logic          en,
    input  logic [7:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mp64_memctl.sv
// Memory controller behind the bus arbiter: serves the low BRAM window
// internally, forwards everything else to an external port with a timeout.
//
// state       | meaning
// MC_IDLE     | waiting for mem_req; BRAM write / read issue / external launch
// MC_RD       | BRAM output valid, formatted into mem_rdata
// MC_EXT_WAIT | ext_req held, waiting for ext_ack or timeout
// MC_ACK      | mem_ack is raised at the end of this state
// MC_DONE     | mem_ack high; stale mem_req from the arbiter is ignored
module mp64_memctl
    import mp64_memctl_pkg::*;
#(
    parameter int unsigned BRAM_BYTES  = 65536,
    parameter int unsigned EXT_TIMEOUT = 1024,
    parameter logic [63:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    input  logic        mem_wen,
    input  logic [1:0]  mem_size,
    output logic [63:0] mem_rdata,
    output logic        mem_ack,
    output logic        ext_req,
    output logic [63:0] ext_addr,
    output logic [63:0] ext_wdata,
    output logic        ext_wen,
    output logic [1:0]  ext_size,
    input  logic [63:0] ext_rdata,
    input  logic        ext_ack,
    output logic        err_timeout
);

    localparam int unsigned LOG2  = $clog2(BRAM_BYTES);
    localparam int unsigned DEPTH = BRAM_BYTES / 8;
    localparam int unsigned IDX_W = (LOG2 > 3) ? LOG2 - 3 : 1;
    localparam int unsigned CNT_W = (EXT_TIMEOUT > 1) ? $clog2(EXT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (EXT_TIMEOUT == 0) ? '0 : CNT_W'(EXT_TIMEOUT - 1);

    mc_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       rd_off;
    logic [1:0]       rd_size;

    logic             hit;
    logic [2:0]       off;
    logic             idle_req;
    logic [7:0]       bram_we;
    logic             bram_en;
    logic [63:0]      bram_wdata;
    logic [63:0]      bram_rdata;
    logic [IDX_W-1:0] bram_idx;

    assign hit        = (mem_addr >> LOG2) == 64'd0;
    assign off        = byte_off(mem_addr[2:0], mem_size);
    assign idle_req   = (state == MC_IDLE) && mem_req && hit;
    // Gating with rst keeps a write all-or-nothing if reset lands in that cycle.
    assign bram_we    = (idle_req && mem_wen && !rst) ? byte_en(off, mem_size) : 8'd0;
    assign bram_en    = idle_req && !mem_wen;
    assign bram_wdata = mem_wdata << {off, 3'b000};
    assign bram_idx   = mem_addr[IDX_W+2:3];

    mp64_bram_be #(
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_bram (
        .clk   (clk),
        .en    (bram_en),
        .we    (bram_we),
        .addr  (bram_idx),
        .wdata (bram_wdata),
        .rdata (bram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= MC_IDLE;
            cnt         <= '0;
            rd_off      <= '0;
            rd_size     <= '0;
            mem_rdata   <= '0;
            mem_ack     <= 1'b0;
            ext_req     <= 1'b0;
            ext_addr    <= '0;
            ext_wdata   <= '0;
            ext_wen     <= 1'b0;
            ext_size    <= '0;
            err_timeout <= 1'b0;
        end else begin
            mem_ack <= 1'b0;
            case (state)
                MC_IDLE: begin
                    if (mem_req) begin
                        if (hit) begin
                            rd_off  <= off;
                            rd_size <= mem_size;
                            state   <= mem_wen ? MC_ACK : MC_RD;
                        end else begin
                            ext_addr  <= mem_addr;
                            ext_wdata <= mem_wdata;
                            ext_wen   <= mem_wen;
                            ext_size  <= mem_size;
                            ext_req   <= 1'b1;
                            cnt       <= '0;
                            state     <= MC_EXT_WAIT;
                        end
                    end
                end
                MC_RD: begin
                    mem_rdata <= fmt_rdata(bram_rdata, rd_off, rd_size);
                    state     <= MC_ACK;
                end
                MC_EXT_WAIT: begin
                    if (ext_ack) begin
                        mem_rdata <= ext_rdata;
                        ext_req   <= 1'b0;
                        state     <= MC_ACK;
                    end else if (EXT_TIMEOUT != 0 && cnt == CNT_LAST) begin
                        mem_rdata   <= ERR_RDATA;
                        ext_req     <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= MC_ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MC_ACK: begin
                    mem_ack <= 1'b1;
                    state   <= MC_DONE;
                end
                MC_DONE: begin
                    state <= MC_IDLE;
                end
                default: begin
                    state <= MC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp64_memctl.sv
// Randomized bench for mp64_memctl against a byte-addressed memory model and
// a latency/response model derived from the request/ack protocol.
module tb_mp64_memctl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wen;
    logic [1:0]  mem_size;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        ext_req;
    logic [63:0] ext_addr;
    logic [63:0] ext_wdata;
    logic        ext_wen;
    logic [1:0]  ext_size;
    logic [63:0] ext_rdata;
    logic        ext_ack;
    logic        err_timeout;

    mp64_memctl #(
        .BRAM_BYTES  (65536),
        .EXT_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wen     (mem_wen),
        .mem_size    (mem_size),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .ext_req     (ext_req),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_wen     (ext_wen),
        .ext_size    (ext_size),
        .ext_rdata   (ext_rdata),
        .ext_ack     (ext_ack),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  bmem [logic [63:0]];
    logic [63:0] exp_rdata = 64'd0;
    logic        exp_err   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [63:0] a, input logic [1:0] sz);
        logic [63:0] base;
        logic [63:0] r;
        int nb;
        nb   = 1 << sz;
        base = a & ~64'(nb - 1);
        r    = 64'd0;
        for (int i = 0; i < nb; i++) begin
            if (bmem.exists(base + 64'(i))) r |= 64'(bmem[base + 64'(i)]) << (8 * i);
        end
        return r;
    endfunction

    task automatic model_write(input logic [63:0] a, input logic [63:0] wd, input logic [1:0] sz);
        logic [63:0] base;
        int nb;
        nb   = 1 << sz;
        base = a & ~64'(nb - 1);
        for (int i = 0; i < nb; i++) bmem[base + 64'(i)] = wd[8*i +: 8];
    endtask

    // One arbiter-style transaction. dly: cycles after ext_req rises before
    // ext_ack is pulsed (external only). Request is held through the ack cycle.
    task automatic xact(input logic [63:0] a, input logic [63:0] wd, input logic wen,
                        input logic [1:0] sz, input int dly, input logic [63:0] erd);
        logic is_ext;
        int   exp_cyc;
        int   got_cyc;
        int   drop_cyc;
        is_ext = (a >> 16) != 64'd0;
        if (!is_ext) begin
            if (wen) begin
                model_write(a, wd, sz);
                exp_cyc = 2;
            end else begin
                exp_rdata = model_read(a, sz);
                exp_cyc   = 3;
            end
        end else if (dly < TMO) begin
            exp_rdata = erd;
            exp_cyc   = 3 + dly;
        end else begin
            exp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
            exp_err   = 1'b1;
            exp_cyc   = TMO + 2;
        end
        drop_cyc = (dly < TMO) ? 2 + dly : TMO + 1;

        @(posedge clk); #1;
        mem_req = 1'b1; mem_addr = a; mem_wdata = wd; mem_wen = wen; mem_size = sz;
        got_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (is_ext && c == 1) begin
                chk("ext_req_up", 64'(ext_req), 64'd1);
                chk("ext_addr", ext_addr, a);
                chk("ext_wdata", ext_wdata, wd);
                chk("ext_wen_size", {61'd0, ext_wen, ext_size}, {61'd0, wen, sz});
            end
            if (is_ext && c == drop_cyc) chk("ext_req_drop", 64'(ext_req), 64'd0);
            if (is_ext && c == 1 + dly) begin
                ext_ack = 1'b1; ext_rdata = erd;
            end else begin
                ext_ack = 1'b0; ext_rdata = {$urandom, $urandom};
            end
            if (mem_ack) begin
                got_cyc = c;
                break;
            end
        end
        ext_ack = 1'b0;
        chk("ack_cycle", 64'(got_cyc), 64'(exp_cyc));
        chk("rdata", mem_rdata, exp_rdata);
        chk("err_timeout", 64'(err_timeout), 64'(exp_err));
        @(posedge clk); #1;
        mem_req = 1'b0;
        @(negedge clk);
        chk("ack_single", 64'(mem_ack), 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        rst = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wen = 1'b0;
        mem_size = '0; ext_rdata = '0; ext_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 64'(mem_ack), 64'd0);
        chk("rst_ext_req", 64'(ext_req), 64'd0);
        chk("rst_rdata", mem_rdata, 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_ext_addr", ext_addr, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Byte write into a zeroed dword, then read back whole dword
        xact(64'h10, 64'd0, 1'b1, 2'd3, 0, 64'd0);
        xact(64'h13, 64'hAB, 1'b1, 2'd0, 0, 64'd0);
        xact(64'h10, 64'd0, 1'b0, 2'd3, 0, 64'd0);
        chk("byte_into_dword", mem_rdata, 64'h0000_0000_AB00_0000);

        xact(64'h10, 64'h1122_3344_5566_7788, 1'b1, 2'd3, 0, 64'd0);
        xact(64'h16, 64'd0, 1'b0, 2'd1, 0, 64'd0);
        chk("half_16", mem_rdata, 64'h1122);
        xact(64'h14, 64'd0, 1'b0, 2'd2, 0, 64'd0);
        chk("word_14", mem_rdata, 64'h1122_3344);
        xact(64'h17, 64'd0, 1'b0, 2'd1, 0, 64'd0);
        chk("half_17_misaligned", mem_rdata, 64'h1122);

        // External read, ack 3 cycles after ext_req rises
        xact(64'h0001_0000, 64'd0, 1'b0, 2'd3, 3, 64'hDEAD);
        chk("ext_dead", mem_rdata, 64'hDEAD);
        // ext_ack in the last cycle before timeout wins
        xact(64'h0002_0040, 64'h55, 1'b1, 2'd0, TMO - 1, 64'h1234);

        // Preload a window and the top dword of the BRAM
        for (int i = 0; i < 64; i++) xact(64'(i * 8), {$urandom, $urandom}, 1'b1, 2'd3, 0, 64'd0);
        xact(64'hFFF8, {$urandom, $urandom}, 1'b1, 2'd3, 0, 64'd0);
        xact(64'hFFFB, 64'd0, 1'b0, 2'd2, 0, 64'd0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                a = 64'($urandom_range(0, 63) * 8 + $urandom_range(0, 7));
                xact(a, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 0, 64'd0);
            end else begin
                a = ($urandom_range(0, 1) != 0) ? 64'h1_0000 + 64'($urandom)
                                                : {$urandom | 32'h100, $urandom};
                xact(a, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), int'($urandom_range(0, TMO - 1)),
                     {$urandom, $urandom});
            end
        end

        // Timeout; the ack that arrives one cycle late must be ignored
        xact(64'h0003_0000, 64'd0, 1'b0, 2'd3, TMO, 64'h0BAD);
        xact(64'h20, 64'd0, 1'b0, 2'd3, 0, 64'd0);
        chk("err_sticky", 64'(err_timeout), 64'd1);

        // Reset while waiting on the external side
        @(posedge clk); #1;
        mem_req = 1'b1; mem_addr = 64'h0004_0000; mem_wen = 1'b0; mem_size = 2'd3;
        repeat (3) @(negedge clk);
        chk("pre_rst_ext_req", 64'(ext_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ext_req", 64'(ext_req), 64'd0);
        chk("mid_rst_ack", 64'(mem_ack), 64'd0);
        chk("mid_rst_err", 64'(err_timeout), 64'd0);
        exp_rdata = 64'd0;
        exp_err   = 1'b0;
        @(posedge clk); #1;
        mem_req = 1'b0;
        rst = 1'b0;
        xact(64'h28, 64'd0, 1'b0, 2'd3, 0, 64'd0);
        xact(64'h2E, 64'd0, 1'b0, 2'd1, 0, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
